// File: rtl/xlr8_tone_pkg.sv
// Shared definitions for the XLR8 multi-channel tone generator.
// Register indices, CTRL/STAT bit positions and the channel state type.
package xlr8_tone_pkg;

  localparam int REG_CTRL  = 0;
  localparam int REG_CHSEL = 1;
  localparam int REG_PERL  = 2;
  localparam int REG_PERH  = 3;
  localparam int REG_DURL  = 4;
  localparam int REG_DURH  = 5;
  localparam int REG_STAT  = 6;
  localparam int NUM_REGS  = 7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_STOP   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY_LSB = 0;
  localparam int STAT_DONE_LSB = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } chan_state_t;

endpackage

// File: rtl/xlr8_tone_chan.sv
// One tone channel: IDLE/PLAY FSM, half-period and duration counters.
// Ports: start/stop/kill strobes, tick, per/dur loads; spk, busy, done_pulse.
module xlr8_tone_chan
  import xlr8_tone_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             kill,
  input  logic             tick,
  input  logic [PER_W-1:0] per,
  input  logic [DUR_W-1:0] dur,
  output logic             spk,
  output logic             busy,
  output logic             done_pulse
);

  chan_state_t      state_q, state_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] hcnt_q, hcnt_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             spk_q, spk_d;
  logic             halt, ld, run;

  // Stop/kill beat a same-cycle start; a load beats a same-cycle tick.
  assign halt = stop | kill;
  assign ld   = start & ~halt;
  assign run  = (state_q == PLAY) & ~halt & ~start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      per_q   <= '0;
      hcnt_q  <= '0;
      rem_q   <= '0;
      spk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      hcnt_q  <= hcnt_d;
      rem_q   <= rem_d;
      spk_q   <= spk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    per_d      = per_q;
    hcnt_d     = hcnt_q;
    rem_d      = rem_q;
    spk_d      = spk_q;
    done_pulse = 1'b0;
    unique case (1'b1)
      halt: begin
        state_d = IDLE;
        hcnt_d  = '0;
        spk_d   = 1'b0;
      end
      ld: begin
        state_d = PLAY;
        per_d   = per;
        rem_d   = dur;
        hcnt_d  = '0;
        spk_d   = 1'b0;
      end
      run: begin
        if (per_q == '0) begin
          hcnt_d = '0;
          spk_d  = 1'b0;
        end else if (hcnt_q == per_q - PER_W'(1)) begin
          hcnt_d = '0;
          spk_d  = ~spk_q;
        end else begin
          hcnt_d = hcnt_q + PER_W'(1);
        end
        // rem loaded as 0 never counts: play until stopped.
        if (tick && rem_q != '0) begin
          rem_d = rem_q - DUR_W'(1);
          if (rem_q == DUR_W'(1)) begin
            state_d    = IDLE;
            hcnt_d     = '0;
            spk_d      = 1'b0;
            done_pulse = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign spk  = spk_q;
  assign busy = (state_q == PLAY);

endmodule

// File: rtl/xlr8_tone_gen.sv
// XLR8 multi-channel square-wave tone generator on the dm_sel/ramadr bus.
// Ports: clk, rstn, bus (clken, dbus_in/out, io_out_en, ramadr, ramre,
// ramwe, dm_sel), spk_out per channel, level tone_irq.
module xlr8_tone_gen
  import xlr8_tone_pkg::*;
#(
  parameter int         NUM_CH     = 2,
  parameter int         PER_W      = 16,
  parameter int         DUR_W      = 16,
  parameter int         TICK_DIV   = 16000,
  parameter logic [7:0] CTRL_ADDR  = 8'h00,
  parameter logic [7:0] CHSEL_ADDR = 8'h00,
  parameter logic [7:0] PERL_ADDR  = 8'h00,
  parameter logic [7:0] PERH_ADDR  = 8'h00,
  parameter logic [7:0] DURL_ADDR  = 8'h00,
  parameter logic [7:0] DURH_ADDR  = 8'h00,
  parameter logic [7:0] STAT_ADDR  = 8'h00
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clken,
  input  logic [7:0]        dbus_in,
  output logic [7:0]        dbus_out,
  output logic              io_out_en,
  input  logic [7:0]        ramadr,
  input  logic              ramre,
  input  logic              ramwe,
  input  logic              dm_sel,
  output logic [NUM_CH-1:0] spk_out,
  output logic              tone_irq
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NUM_REGS-1:0] sel;
  logic [NUM_REGS-1:0] we;
  logic                en_q;
  logic                irq_en_q;
  logic [1:0]          chsel_q;
  logic [PER_W-1:0]    per_sh [NUM_CH];
  logic [DUR_W-1:0]    dur_sh [NUM_CH];
  logic [NUM_CH-1:0]   done_q;
  logic [NUM_CH-1:0]   busy;
  logic [NUM_CH-1:0]   done_pulse;
  logic [NUM_CH-1:0]   ch_start;
  logic [NUM_CH-1:0]   ch_stop;
  logic [NUM_CH-1:0]   w1c;
  logic                start_wr;
  logic                stop_wr;
  logic                kill;
  logic [TW-1:0]       pre_q;
  logic                tick;
  logic [15:0]         per_rd;
  logic [15:0]         dur_rd;

  assign sel[REG_CTRL]  = dm_sel && (ramadr == CTRL_ADDR);
  assign sel[REG_CHSEL] = dm_sel && (ramadr == CHSEL_ADDR);
  assign sel[REG_PERL]  = dm_sel && (ramadr == PERL_ADDR);
  assign sel[REG_PERH]  = dm_sel && (ramadr == PERH_ADDR);
  assign sel[REG_DURL]  = dm_sel && (ramadr == DURL_ADDR);
  assign sel[REG_DURH]  = dm_sel && (ramadr == DURH_ADDR);
  assign sel[REG_STAT]  = dm_sel && (ramadr == STAT_ADDR);
  assign we = sel & {NUM_REGS{ramwe & clken}};

  // Start/kill follow the EN value being written, so EN|START starts at once.
  assign start_wr = we[REG_CTRL] & dbus_in[CTRL_START] & dbus_in[CTRL_EN];
  assign stop_wr  = we[REG_CTRL] & dbus_in[CTRL_STOP];
  assign kill     = we[REG_CTRL] & ~dbus_in[CTRL_EN];
  assign w1c = we[REG_STAT] ? dbus_in[STAT_DONE_LSB +: NUM_CH] : '0;

  assign tick = (pre_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      chsel_q  <= '0;
      done_q   <= '0;
      tone_irq <= 1'b0;
    end else begin
      if (we[REG_CTRL]) begin
        en_q     <= dbus_in[CTRL_EN];
        irq_en_q <= dbus_in[CTRL_IRQ_EN];
      end
      if (we[REG_CHSEL]) begin
        chsel_q <= dbus_in[1:0];
      end
      done_q   <= (done_q & ~w1c) | done_pulse;
      tone_irq <= irq_en_q & (|done_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        per_sh[i] <= '0;
        dur_sh[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (chsel_q == 2'(i)) begin
          if (we[REG_PERL]) per_sh[i][7:0] <= dbus_in;
          if (we[REG_PERH])
            per_sh[i][PER_W-1:8] <= dbus_in[PER_W-9:0];
          if (we[REG_DURL]) dur_sh[i][7:0] <= dbus_in;
          if (we[REG_DURH])
            dur_sh[i][DUR_W-1:8] <= dbus_in[DUR_W-9:0];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_start[i] = start_wr & (chsel_q == 2'(i));
    assign ch_stop[i]  = stop_wr & (chsel_q == 2'(i));

    xlr8_tone_chan #(
      .PER_W (PER_W),
      .DUR_W (DUR_W)
    ) u_chan (
      .clk        (clk),
      .rstn       (rstn),
      .start      (ch_start[i]),
      .stop       (ch_stop[i]),
      .kill       (kill),
      .tick       (tick),
      .per        (per_sh[i]),
      .dur        (dur_sh[i]),
      .spk        (spk_out[i]),
      .busy       (busy[i]),
      .done_pulse (done_pulse[i])
    );
  end

  // Out-of-range CHSEL matches no channel, so these read 0.
  always_comb begin
    per_rd = '0;
    dur_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chsel_q == 2'(i)) begin
        per_rd = 16'(per_sh[i]);
        dur_rd = 16'(dur_sh[i]);
      end
    end
  end

  // OR-mux keeps reads well defined even if addresses alias.
  always_comb begin
    dbus_out = '0;
    if (sel[REG_CTRL])
      dbus_out = dbus_out | {4'b0, irq_en_q, 2'b0, en_q};
    if (sel[REG_CHSEL])
      dbus_out = dbus_out | {6'b0, chsel_q};
    if (sel[REG_PERL]) dbus_out = dbus_out | per_rd[7:0];
    if (sel[REG_PERH]) dbus_out = dbus_out | per_rd[15:8];
    if (sel[REG_DURL]) dbus_out = dbus_out | dur_rd[7:0];
    if (sel[REG_DURH]) dbus_out = dbus_out | dur_rd[15:8];
    if (sel[REG_STAT])
      dbus_out = dbus_out | {4'(done_q), 4'(busy)};
  end

  assign io_out_en = ramre & (|sel);

endmodule

// File: tb/tb_xlr8_tone_gen.sv
// Directed self-checking bench for xlr8_tone_gen.
// Two channels, PER_W=12, TICK_DIV=1, distinct register addresses.
module tb_xlr8_tone_gen;

  localparam logic [7:0] A_CTRL  = 8'h20;
  localparam logic [7:0] A_CHSEL = 8'h21;
  localparam logic [7:0] A_PERL  = 8'h22;
  localparam logic [7:0] A_PERH  = 8'h23;
  localparam logic [7:0] A_DURL  = 8'h24;
  localparam logic [7:0] A_DURH  = 8'h25;
  localparam logic [7:0] A_STAT  = 8'h26;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clken = 1'b0;
  logic [7:0] dbus_in = '0;
  logic [7:0] dbus_out;
  logic       io_out_en;
  logic [7:0] ramadr = '0;
  logic       ramre = 1'b0;
  logic       ramwe = 1'b0;
  logic       dm_sel = 1'b0;
  logic [1:0] spk_out;
  logic       tone_irq;

  int errors = 0;
  int checks = 0;

  xlr8_tone_gen #(
    .NUM_CH     (2),
    .PER_W      (12),
    .DUR_W      (16),
    .TICK_DIV   (1),
    .CTRL_ADDR  (A_CTRL),
    .CHSEL_ADDR (A_CHSEL),
    .PERL_ADDR  (A_PERL),
    .PERH_ADDR  (A_PERH),
    .DURL_ADDR  (A_DURL),
    .DURH_ADDR  (A_DURH),
    .STAT_ADDR  (A_STAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clken     (clken),
    .dbus_in   (dbus_in),
    .dbus_out  (dbus_out),
    .io_out_en (io_out_en),
    .ramadr    (ramadr),
    .ramre     (ramre),
    .ramwe     (ramwe),
    .dm_sel    (dm_sel),
    .spk_out   (spk_out),
    .tone_irq  (tone_irq)
  );

  always #5 clk = ~clk;

  task automatic wr_ce(input logic [7:0] a,
                       input logic [7:0] d,
                       input logic ce);
    @(negedge clk);
    ramadr  = a;
    dbus_in = d;
    dm_sel  = 1'b1;
    ramwe   = 1'b1;
    clken   = ce;
    @(posedge clk);
    #1;
    dm_sel = 1'b0;
    ramwe  = 1'b0;
    clken  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_ce(a, d, 1'b1);
  endtask

  // Combinational read; call only just after a negedge.
  task automatic rd(input logic [7:0] a,
                    output logic [7:0] d,
                    output logic v);
    ramadr = a;
    dm_sel = 1'b1;
    ramre  = 1'b1;
    #1;
    d = dbus_out;
    v = io_out_en;
    dm_sel = 1'b0;
    ramre  = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic v;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (spk_out !== 2'b00 || tone_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: spk=%b irq=%b want 00/0",
               spk_out, tone_irq);
    end
    rd(A_STAT, d, v);
    checks++;
    if (d !== 8'h00 || v !== 1'b1) begin
      errors++;
      $display("FAIL reset_stat: got %h v=%b want 00 v=1", d, v);
    end
    rd(A_CTRL, d, v);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %h want 00", d);
    end
  endtask

  task automatic test_basic_tone();
    logic [7:0] d;
    logic v;
    logic es;
    logic [7:0] est;
    wr(A_PERL, 8'd3);
    wr(A_PERH, 8'd0);
    wr(A_DURL, 8'd20);
    wr(A_DURH, 8'd0);
    wr(A_CTRL, 8'h03);
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      es  = (k < 20) ? (((k / 3) % 2) == 1) : 1'b0;
      est = (k < 20) ? 8'h01 : 8'h10;
      rd(A_STAT, d, v);
      checks++;
      if (spk_out !== {1'b0, es} || d !== est || tone_irq !== 1'b0) begin
        errors++;
        $display("FAIL basic k=%0d: spk=%b stat=%h irq=%b want %b %h 0",
                 k, spk_out, d, tone_irq, {1'b0, es}, est);
      end
    end
  endtask

  task automatic test_irq();
    logic ei;
    wr(A_STAT, 8'h10);
    wr(A_CTRL, 8'h0B);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      ei = (k >= 21);
      checks++;
      if (tone_irq !== ei) begin
        errors++;
        $display("FAIL irq_set k=%0d: got %b want %b", k, tone_irq, ei);
      end
    end
    wr(A_STAT, 8'h10);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tone_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr: got %b want 0", tone_irq);
    end
  endtask

  task automatic test_continuous_stop();
    logic [7:0] d;
    logic v;
    logic es;
    int bad;
    bad = 0;
    wr(A_CHSEL, 8'd1);
    wr(A_DURL, 8'd0);
    wr(A_DURH, 8'd0);
    wr(A_PERL, 8'd5);
    wr(A_PERH, 8'd0);
    wr(A_CTRL, 8'h03);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      es = ((k / 5) % 2) == 1;
      checks++;
      if (spk_out !== {es, 1'b0}) begin
        errors++;
        if (bad < 5)
          $display("FAIL cont k=%0d: spk=%b want %b",
                   k, spk_out, {es, 1'b0});
        bad++;
      end
    end
    rd(A_STAT, d, v);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL cont_busy: stat=%h want 02", d);
    end
    wr(A_CTRL, 8'h05);
    @(negedge clk);
    rd(A_STAT, d, v);
    checks++;
    if (spk_out !== 2'b00 || d !== 8'h00) begin
      errors++;
      $display("FAIL stop: spk=%b stat=%h want 00 00", spk_out, d);
    end
  endtask

  task automatic test_restart();
    logic [7:0] d;
    logic v;
    logic es;
    logic [7:0] est;
    int bad;
    bad = 0;
    wr(A_CHSEL, 8'd0);
    wr(A_PERL, 8'd4);
    wr(A_DURL, 8'd50);
    wr(A_CTRL, 8'h03);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      es = ((k / 4) % 2) == 1;
      checks++;
      if (spk_out !== {1'b0, es}) begin
        errors++;
        $display("FAIL pre_restart k=%0d: spk=%b want %b",
                 k, spk_out, {1'b0, es});
      end
    end
    wr(A_PERL, 8'd2);
    wr(A_CTRL, 8'h03);
    for (int k = 0; k < 53; k++) begin
      @(negedge clk);
      es  = (k < 50) ? (((k / 2) % 2) == 1) : 1'b0;
      est = (k < 50) ? 8'h01 : 8'h10;
      rd(A_STAT, d, v);
      checks++;
      if (spk_out !== {1'b0, es} || d !== est) begin
        errors++;
        if (bad < 5)
          $display("FAIL restart k=%0d: spk=%b stat=%h want %b %h",
                   k, spk_out, d, {1'b0, es}, est);
        bad++;
      end
    end
    wr(A_STAT, 8'h10);
  endtask

  task automatic test_enable();
    logic [7:0] d;
    logic v;
    wr(A_CTRL, 8'h01);
    wr(A_PERL, 8'd7);
    wr(A_CTRL, 8'h02);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rd(A_STAT, d, v);
      checks++;
      if (spk_out !== 2'b00 || d !== 8'h00) begin
        errors++;
        $display("FAIL en0_start k=%0d: spk=%b stat=%h want 00 00",
                 k, spk_out, d);
      end
    end
    wr(A_CHSEL, 8'd1);
    wr(A_CTRL, 8'h03);
    wr(A_CHSEL, 8'd0);
    wr(A_CTRL, 8'h03);
    repeat (3) @(negedge clk);
    rd(A_STAT, d, v);
    checks++;
    if (d !== 8'h03) begin
      errors++;
      $display("FAIL both_busy: stat=%h want 03", d);
    end
    wr(A_CTRL, 8'h00);
    @(negedge clk);
    rd(A_STAT, d, v);
    checks++;
    if (spk_out !== 2'b00 || d !== 8'h00) begin
      errors++;
      $display("FAIL en_clear: spk=%b stat=%h want 00 00", spk_out, d);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] d;
    logic v;
    wr(A_CHSEL, 8'd0);
    wr(A_PERH, 8'hFF);
    @(negedge clk);
    rd(A_PERH, d, v);
    checks++;
    if (d !== 8'h0F) begin
      errors++;
      $display("FAIL perh_trunc: got %h want 0F", d);
    end
    rd(A_PERL, d, v);
    checks++;
    if (d !== 8'h07) begin
      errors++;
      $display("FAIL perl_rb: got %h want 07", d);
    end
    wr(A_DURH, 8'hAB);
    @(negedge clk);
    rd(A_DURH, d, v);
    checks++;
    if (d !== 8'hAB) begin
      errors++;
      $display("FAIL durh_rb: got %h want AB", d);
    end
    wr(A_CTRL, 8'h07);
    @(negedge clk);
    rd(A_STAT, d, v);
    checks++;
    if (d !== 8'h00 || spk_out !== 2'b00) begin
      errors++;
      $display("FAIL start_stop: stat=%h spk=%b want 00 00", d, spk_out);
    end
    wr(A_CHSEL, 8'd3);
    @(negedge clk);
    rd(A_PERL, d, v);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL chsel3_per: got %h want 00", d);
    end
    rd(A_CHSEL, d, v);
    checks++;
    if (d !== 8'h03) begin
      errors++;
      $display("FAIL chsel_rb: got %h want 03", d);
    end
    wr(A_CTRL, 8'h0B);
    @(negedge clk);
    rd(A_STAT, d, v);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL chsel3_start: stat=%h want 00", d);
    end
    rd(A_CTRL, d, v);
    checks++;
    if (d !== 8'h09) begin
      errors++;
      $display("FAIL ctrl_rb: got %h want 09", d);
    end
    wr_ce(A_CHSEL, 8'd0, 1'b0);
    @(negedge clk);
    rd(A_CHSEL, d, v);
    checks++;
    if (d !== 8'h03) begin
      errors++;
      $display("FAIL clken_gate: got %h want 03", d);
    end
  endtask

  task automatic test_read_enable();
    @(negedge clk);
    ramadr = A_CTRL;
    dm_sel = 1'b0;
    ramre  = 1'b1;
    #1;
    checks++;
    if (io_out_en !== 1'b0) begin
      errors++;
      $display("FAIL oe_nosel: got %b want 0", io_out_en);
    end
    dm_sel = 1'b1;
    ramre  = 1'b0;
    #1;
    checks++;
    if (io_out_en !== 1'b0) begin
      errors++;
      $display("FAIL oe_nore: got %b want 0", io_out_en);
    end
    ramadr = 8'h7F;
    ramre  = 1'b1;
    #1;
    checks++;
    if (io_out_en !== 1'b0) begin
      errors++;
      $display("FAIL oe_badaddr: got %b want 0", io_out_en);
    end
    ramadr = A_CTRL;
    #1;
    checks++;
    if (io_out_en !== 1'b1 || dbus_out !== 8'h09) begin
      errors++;
      $display("FAIL oe_read: oe=%b d=%h want 1 09", io_out_en, dbus_out);
    end
    dm_sel = 1'b0;
    ramre  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_tone();
    test_irq();
    test_continuous_stop();
    test_restart();
    test_enable();
    test_boundary();
    test_read_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xlr8_tone_gen.md
Name: xlr8_tone_gen

Overview:
Multi-channel square-wave tone generator for the XLR8 AVR data-memory bus, successor to the single on/off speaker block. Each channel has a programmable half-period and a programmable duration, and runs a per-channel state machine. A channel stops by itself when its duration expires and raises a sticky done flag, with an optional interrupt. The block sits on the dm_sel/ramadr register bus beside other XBs and drives speaker pins directly.

Parameters:
NUM_CH, 2, number of tone channels (1..4).
PER_W, 16, half-period counter width in clk cycles (9..16).
DUR_W, 16, duration counter width in ticks (9..16).
TICK_DIV, 16000, clk cycles per duration tick (>=1); 16000 gives 1 ms at 16 MHz.
CTRL_ADDR, 0, control register address.
CHSEL_ADDR, 0, channel-select register address.
PERL_ADDR / PERH_ADDR, 0, half-period low/high byte addresses.
DURL_ADDR / DURH_ADDR, 0, duration low/high byte addresses.
STAT_ADDR, 0, status register address.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
clken  in  1  bus clock enable; qualifies register writes only
dbus_in  in  8  write data
dbus_out  out  8  read data
io_out_en  out  1  read-data valid
ramadr  in  8  register address
ramre  in  1  read enable
ramwe  in  1  write enable
dm_sel  in  1  data-memory select
spk_out  out  NUM_CH  speaker pin per channel
tone_irq  out  1  interrupt, level

Behaviour:
- Reset: rstn asynchronous, active-low; clock clk. All registers, shadows and counters are 0. spk_out=0, tone_irq=0, every channel IDLE.
- Register decode: sel = dm_sel && ramadr==X_ADDR. A write takes effect on the clk edge when sel && ramwe && clken.
- Read path: dbus_out is combinationally muxed from the selected register. io_out_en = OR of every sel && ramre.
- CTRL bits:
  - [0] EN: global enable, R/W.
  - [1] START: strobe, reads 0.
  - [2] STOP: strobe, reads 0.
  - [3] IRQ_EN: R/W.
  - [7:4] read 0.
- CHSEL[1:0] selects channel c for the PER, DUR and START/STOP accesses. A value >= NUM_CH makes those accesses no-ops, and reads of them return 0.
- PERL/PERH/DURL/DURH write and read the shadow registers of channel c. Bits above PER_W/DUR_W are dropped on write and read back 0. Shadows are used only when START is issued, so byte write order is free.
- Tick prescaler: free-running counter 0..TICK_DIV-1. tick pulses for 1 cycle when it wraps; with TICK_DIV=1, tick=1 every cycle.
- Per-channel FSM IDLE -> PLAY:
  - START with EN=1, written at edge N: at N, load per=shadow_per, rem=shadow_dur, hcnt=0, spk=0. State is PLAY and busy=1 from N+1.
  - PLAY, per!=0: hcnt increments every cycle. When hcnt==per-1, spk toggles and hcnt=0. Output period is 2*per cycles; first rising edge is per cycles after N.
  - PLAY, per==0: spk held 0 (silent rest); duration still counts.
  - Duration: on each tick, if rem!=0, rem-=1. When rem goes 1->0: IDLE, spk=0, done[c]=1.
  - rem loaded as 0: play until STOP; done never set.
  - STOP: IDLE, spk=0, done unchanged.
- Boundary cases:
  - START while in PLAY: restart with the new shadows.
  - START and STOP in the same write: STOP wins.
  - START with EN=0: ignored.
  - EN written 0: all channels go to IDLE, spk=0, done unchanged.
  - tick and START on the same edge: the load wins, and that tick is not counted.
  - Duration accuracy is -1/+0 ticks when TICK_DIV>1.
- STAT register:
  - [3:0] busy per channel, read-only.
  - [7:4] done per channel, write-1-to-clear.
  - If a done set and its W1C land on the same edge, set wins.
  - Unused channel bits read 0.
- tone_irq = IRQ_EN && |done, registered, 1-cycle latency from the done set.

Decomposition:
- Package xlr8_tone_pkg holds:
  - register offset indices;
  - CTRL bit positions (EN, START, STOP, IRQ_EN);
  - STAT field positions;
  - chan_state_t enum {IDLE, PLAY}.
- Sub-module xlr8_tone_chan holds one channel's FSM plus its half-period and duration counters. Its inputs are start, stop, kill, tick, per, dur; its outputs are spk, busy, done_pulse. It is instantiated NUM_CH times in a generate loop.
- The top level holds bus decode, shadows, CTRL/CHSEL/STAT and the prescaler.

Test Plan:
- Reset, TICK_DIV=1: write PER=3, DUR=20, CTRL=0x03 at cycle 0 -> spk_out[0] rises at cycle 3, period 6; busy=1 for exactly 20 cycles, then spk=0 and STAT=0x10.
- Same run with IRQ_EN=1 -> tone_irq=1 one cycle after done. Write STAT=0x10 -> tone_irq=0 the next cycle.
- CHSEL=1, DUR=0, PER=5, START -> ch1 plays continuously while ch0 stays 0. After 200 cycles write STOP -> spk_out[1]=0, STAT[5]=0.
- Restart mid-tone: PER=4, DUR=50, START; at cycle 10 write PER=2 and START -> hcnt restarts, toggles every 2 cycles, 50-cycle duration counted from the restart.
- Write CTRL=0x01 (EN) then PER=7, START with EN=0 -> no output. Clear EN during PLAY -> all outputs 0 and busy=0 the next cycle.
- Read-back and boundaries:
  - Write PERH=0xFF with PER_W=12 -> reads 0x0F.
  - CHSEL=3 with NUM_CH=2 -> PER reads 0x00 and START does nothing.
  - dbus_out/io_out_en valid only when dm_sel && ramre.
